sub64_result_stage: RTL and testbench



---
 rtl/sub64_pkg.sv | 24 ++
 rtl/sub64_fifo2.sv | 52 +++++
 rtl/sub64_result_stage.sv | 71 +++++++
 tb/tb_sub64_result_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sub64_pkg.sv
// rtl/sub64_pkg.sv - shared types and constants for the 64-bit subtractor result stage
package sub64_pkg;

   localparam int SUB64_W = 64;
   localparam logic [SUB64_W-1:0] SUB64_SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [SUB64_W-1:0] SUB64_SAT_MIN = 64'h8000_0000_0000_0000;

   typedef struct packed {
      logic [SUB64_W-1:0] result;
      logic               overflow;
   } sub64_entry_t;

   // An overflowed difference clamps toward the sign of A: negative A can only underflow.
   function automatic logic [SUB64_W-1:0] sub64_saturate(
      input logic [SUB64_W-1:0] result,
      input logic               overflow,
      input logic               a_sign
   );
      if (!overflow)
         return result;
      return a_sign ? SUB64_SAT_MIN : SUB64_SAT_MAX;
   endfunction

endpackage

// File: rtl/sub64_fifo2.sv
// rtl/sub64_fifo2.sv - two-entry valid/ready FIFO of sub64_entry_t with registered storage
module sub64_fifo2
   import sub64_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  sub64_entry_t in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output sub64_entry_t out_data
);

   logic [1:0]   cnt;
   logic         head;
   logic         tail;
   sub64_entry_t mem [2];
   logic         push;
   logic         pop;

   // Ready depends only on occupancy, so the producer never sees out_ready combinationally.
   assign in_ready  = (cnt != 2'd2) && !rst;
   assign out_valid = (cnt != 2'd0);
   assign out_data  = mem[head];

   assign push = in_valid && (cnt != 2'd2);
   assign pop  = out_ready && (cnt != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= 2'd0;
         head   <= 1'b0;
         tail   <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[tail] <= in_data;
            tail      <= ~tail;
         end
         if (pop)
            head <= ~head;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sub64_result_stage.sv
// rtl/sub64_result_stage.sv - buffered result stage with overflow status; SUB64_SAT_EN enables saturation
module sub64_result_stage
   import sub64_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SUB64_W-1:0] in_result,
   input  logic               in_overflow,
   input  logic               in_a_sign,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SUB64_W-1:0] out_result,
   output logic               out_overflow,
   input  logic               clr_status,
   output logic               ovf_sticky,
   output logic [COUNT_W-1:0] ovf_count
);

   sub64_entry_t wr_entry;
   sub64_entry_t rd_entry;
   logic         accept;
   logic         ovf_accept;

`ifdef SUB64_SAT_EN
   assign wr_entry.result = sub64_saturate(in_result, in_overflow, in_a_sign);
`else
   logic unused_a_sign;
   assign unused_a_sign   = in_a_sign;
   assign wr_entry.result = in_result;
`endif
   assign wr_entry.overflow = in_overflow;

   sub64_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (wr_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (rd_entry)
   );

   assign out_result   = rd_entry.result;
   assign out_overflow = rd_entry.overflow;

   assign accept     = in_valid && in_ready;
   assign ovf_accept = accept && in_overflow;

   // A clear coinciding with an overflow accept clears first, then counts that overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (ovf_accept) begin
         ovf_sticky <= 1'b1;
         if (clr_status)
            ovf_count <= COUNT_W'(1);
         else if (ovf_count != '1)
            ovf_count <= ovf_count + COUNT_W'(1);
      end else if (clr_status) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end
   end

endmodule

// File: tb/tb_sub64_result_stage.sv
// tb/tb_sub64_result_stage.sv - scoreboard bench for sub64_result_stage
module tb_sub64_result_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_result = '0;
   logic        in_overflow = 1'b0;
   logic        in_a_sign = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_status = 1'b0;

   logic        in_ready, out_valid, out_overflow, ovf_sticky;
   logic [63:0] out_result;
   logic [15:0] ovf_count;

   logic        in_ready2, out_valid2, out_overflow2, ovf_sticky2;
   logic [63:0] out_result2;
   logic [1:0]  ovf_count2;

   int total = 0;
   int bad   = 0;

   logic [64:0] q[$];
   logic        m_stk = 1'b0;
   logic [15:0] m_cnt = '0;
   logic [1:0]  m_cnt2 = '0;
   bit          acc;

   always #5 clk = ~clk;

   sub64_result_stage #(.COUNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_overflow(in_overflow), .in_a_sign(in_a_sign),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_overflow(out_overflow), .clr_status(clr_status),
      .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
   );

   sub64_result_stage #(.COUNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_result(in_result), .in_overflow(in_overflow), .in_a_sign(in_a_sign),
      .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
      .out_overflow(out_overflow2), .clr_status(clr_status),
      .ovf_sticky(ovf_sticky2), .ovf_count(ovf_count2)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_res(input logic [63:0] r, input logic o, input logic s);
`ifdef SUB64_SAT_EN
      if (o)
         return s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return r;
   endfunction

   task automatic cycle(output bit accepted);
      bit          push, pop;
      logic [64:0] e;
      @(negedge clk);
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, q.size() != 2});
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      check_eq("ovf_sticky", {63'd0, ovf_sticky}, {63'd0, m_stk});
      check_eq("ovf_count", {48'd0, ovf_count}, {48'd0, m_cnt});
      check_eq("ovf_count_w2", {62'd0, ovf_count2}, {62'd0, m_cnt2});
      push = in_valid && (q.size() != 2);
      pop  = out_ready && (q.size() != 0);
      if (pop) begin
         e = q.pop_front();
         check_eq("out_result", out_result, e[63:0]);
         check_eq("out_overflow", {63'd0, out_overflow}, {63'd0, e[64]});
      end
      if (push)
         q.push_back({in_overflow, exp_res(in_result, in_overflow, in_a_sign)});
      if (push && in_overflow) begin
         m_stk = 1'b1;
         if (clr_status) begin
            m_cnt  = 16'd1;
            m_cnt2 = 2'd1;
         end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
         end
      end else if (clr_status) begin
         m_stk  = 1'b0;
         m_cnt  = '0;
         m_cnt2 = '0;
      end
      accepted = push;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] r, input logic o, input logic s);
      bit a;
      a = 0;
      in_valid    = 1'b1;
      in_result   = r;
      in_overflow = o;
      in_a_sign   = s;
      for (int i = 0; i < 20 && !a; i++)
         cycle(a);
      check_eq("send_accept", {63'd0, a}, 64'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cycle(acc);
   endtask

   initial begin
      // reset with a pending input
      #1 rst = 1'b1;
      in_valid  = 1'b1;
      in_result = 64'd5;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_out_result", out_result, 64'd0);
      check_eq("rst_out_overflow", {63'd0, out_overflow}, 64'd0);
      check_eq("rst_sticky", {63'd0, ovf_sticky}, 64'd0);
      check_eq("rst_count", {48'd0, ovf_count}, 64'd0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check_eq("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      in_valid = 1'b0;

      // streaming
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++)
         send(64'(i), 1'b0, 1'b0);
      idle(3);
      check_eq("stream_drain", 64'(q.size()), 64'd0);

      // backpressure
      out_ready = 1'b0;
      send(64'hA1, 1'b0, 1'b0);
      send(64'hB2, 1'b0, 1'b0);
      in_valid  = 1'b1;
      in_result = 64'hC3;
      for (int i = 0; i < 3; i++) begin
         cycle(acc);
         check_eq("bp_stall", {63'd0, acc}, 64'd0);
      end
      out_ready = 1'b1;
      send(64'hC3, 1'b0, 1'b0);
      idle(4);
      check_eq("bp_drain", 64'(q.size()), 64'd0);

      // saturation or raw pass-through
      send(64'h8000_0000_0000_0000, 1'b1, 1'b0);
      send(64'h7FFF_FFFF_FFFF_FFF0, 1'b1, 1'b1);
      send(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
      idle(3);

      // status
      clr_status = 1'b1;
      idle(1);
      clr_status = 1'b0;
      for (int i = 0; i < 3; i++)
         send(64'h100 + 64'(i), 1'b1, 1'(i));
      idle(2);
      check_eq("status_cnt3", {48'd0, ovf_count}, 64'd3);
      check_eq("status_sticky", {63'd0, ovf_sticky}, 64'd1);
      clr_status = 1'b1;
      idle(1);
      clr_status = 1'b0;
      check_eq("clr_cnt", {48'd0, ovf_count}, 64'd0);
      check_eq("clr_sticky", {63'd0, ovf_sticky}, 64'd0);
      send(64'd3, 1'b1, 1'b0);
      send(64'd4, 1'b1, 1'b0);
      clr_status = 1'b1;
      send(64'd5, 1'b1, 1'b0);
      clr_status = 1'b0;
      in_valid = 1'b0;
      check_eq("clr_ovf_cnt", {48'd0, ovf_count}, 64'd1);
      check_eq("clr_ovf_sticky", {63'd0, ovf_sticky}, 64'd1);
      for (int i = 0; i < 5; i++)
         send(64'h200 + 64'(i), 1'b1, 1'b0);
      idle(3);
      check_eq("cnt_w2_hold", {62'd0, ovf_count2}, 64'd3);
      check_eq("cnt_w16_six", {48'd0, ovf_count}, 64'd6);

      // reset mid-operation discards buffered entries
      out_ready = 1'b0;
      send(64'hD4, 1'b1, 1'b0);
      send(64'hE5, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      check_eq("midrst_count", {48'd0, ovf_count}, 64'd0);
      q.delete();
      m_stk  = 1'b0;
      m_cnt  = '0;
      m_cnt2 = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      idle(2);
      send(64'hF6, 1'b0, 1'b0);
      idle(2);
      check_eq("final_drain", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
